// File: rtl/fix2single_arbiter.sv
// fix2single_arbiter
// Round-robin arbiter that shares one fixed-to-float converter among NUM_REQ producers.
// A single request is accepted, pushed through the converter's input handshake, awaited
// under a timeout, and the 32-bit result is returned tagged with the requester index.
//
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready/req_data   per-requester operand handshake, operand i at [i*W +: W]
//   cnv_valid_in/cnv_ready_in      operand handshake towards the converter
//   cnv_fixed_point                operand presented to the converter
//   cnv_valid_out/cnv_ready_out    result handshake from the converter
//   cnv_data_out                   single-precision result from the converter
//   out_valid/out_ready            result handshake towards downstream
//   out_data/out_id                result and the index of the requester it belongs to
//   busy                           high whenever a transaction is in progress
//   timeout_err                    sticky flag, set when the converter fails to answer
module fix2single_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned INT_WIDTH   = 8,
  parameter int unsigned FRACT_WIDTH = 8,
  parameter int unsigned TIMEOUT     = 64,
  localparam int unsigned W          = INT_WIDTH + FRACT_WIDTH,
  localparam int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_data,
  output logic                 cnv_valid_in,
  input  logic                 cnv_ready_in,
  output logic [W-1:0]         cnv_fixed_point,
  input  logic                 cnv_valid_out,
  output logic                 cnv_ready_out,
  input  logic [31:0]          cnv_data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [ID_W-1:0]      out_id,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [W-1:0]      operand_q, operand_d;
  logic [31:0]       result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [ID_W-1:0]   grant;
  logic              any_valid;
  logic [W-1:0]      req_ops [NUM_REQ];

  // Modulo-NUM_REQ increment; NUM_REQ need not be a power of two.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return id + ID_W'(1);
  endfunction

  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
    assign req_ops[i] = req_data[i*W +: W];
  end

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    logic [ID_W-1:0] cand;
    grant     = '0;
    any_valid = 1'b0;
    cand      = rr_ptr_q;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!any_valid && req_valid[cand]) begin
        grant     = cand;
        any_valid = 1'b1;
      end
      cand = next_id(cand);
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    operand_d     = operand_q;
    result_d      = result_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    req_ready     = '0;
    cnv_valid_in  = 1'b0;
    cnv_ready_out = 1'b0;
    out_valid     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          req_ready[grant] = 1'b1;
          id_d             = grant;
          operand_d        = req_ops[grant];
          state_d          = StIssue;
        end
      end
      StIssue: begin
        cnv_valid_in = 1'b1;
        if (cnv_ready_in) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        cnv_ready_out = 1'b1;
        cnt_d         = cnt_q + CNT_W'(1);
        // A result arriving on the last allowed cycle still wins over the abort.
        if (cnv_valid_out) begin
          result_d = cnv_data_out;
          state_d  = StDeliver;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          rr_ptr_d = next_id(id_q);
          state_d  = StIdle;
        end
      end
      StDeliver: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rr_ptr_d = next_id(id_q);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      operand_q <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign cnv_fixed_point = operand_q;
  assign out_data        = result_q;
  assign out_id          = id_q;
  assign busy            = (state_q != StIdle);
  assign timeout_err     = err_q;

endmodule

// File: tb/tb_fix2single_arbiter.sv
// Bench for fix2single_arbiter: requester and converter models drive the DUT, a monitor
// keeps a transaction-level model of the arbiter and a scoreboard of expected results.
module tb_fix2single_arbiter;
  localparam int NR = 4;
  localparam int W  = 16;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*W-1:0]   req_data;
  logic              cnv_valid_in, cnv_ready_in, cnv_valid_out, cnv_ready_out;
  logic [W-1:0]      cnv_fixed_point;
  logic [31:0]       cnv_data_out, out_data;
  logic              out_valid, out_ready, busy, timeout_err;
  logic [1:0]        out_id;

  fix2single_arbiter #(
    .NUM_REQ(NR), .INT_WIDTH(8), .FRACT_WIDTH(8), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .cnv_valid_in(cnv_valid_in), .cnv_ready_in(cnv_ready_in),
    .cnv_fixed_point(cnv_fixed_point),
    .cnv_valid_out(cnv_valid_out), .cnv_ready_out(cnv_ready_out),
    .cnv_data_out(cnv_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Unsigned Q8.8 to IEEE-754 single; exact for 16-bit operands.
  function automatic logic [31:0] fix2float(input logic [W-1:0] v);
    int p;
    logic [31:0] m;
    if (v == '0) return 32'h0;
    p = 0;
    for (int b = 0; b < W; b++) if (v[b]) p = b;
    m = {16'h0, v} << (23 - p);
    return {1'b0, 8'(p - 8 + 127), m[22:0]};
  endfunction

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] op;
    logic [31:0]  data;
  } exp_t;

  // Transaction-level model state
  exp_t        sb[$];
  int          m_ptr = 0;
  int          m_phase = 0;     // 0 idle, 1 operand pending, 2 awaiting result, 3 result out
  int          wcnt = 0;
  logic        exp_err = 1'b0;
  int          n_deliv = 0, n_tmo = 0, n_grant = 0;
  int          hs_cnt[NR] = '{default: 0};
  int          glog[$];
  logic [31:0] dlog[$];
  int          ilog[$];

  // Samples taken at negedge, consumed by the drivers after the next posedge
  logic [NR-1:0] s_rr = '0;
  logic          s_hs_in = 1'b0, s_hs_out = 1'b0;
  logic [W-1:0]  s_op = '0;

  // Driver knobs
  logic          auto_req = 1'b0;
  logic [NR-1:0] sticky = '0;
  int            cv_lat = 2, cv_ready_pct = 100, cv_hang_pct = 0;
  logic          cv_hang = 1'b0;
  int            cv_phase = 0, cv_left = 0;
  logic [31:0]   cv_res = '0;

  initial forever begin
    @(negedge rst);
    sb.delete();
    m_ptr = 0; m_phase = 0; wcnt = 0; exp_err = 1'b0;
  end

  // Monitor / scoreboard
  initial begin
    exp_t          e;
    int            g;
    logic [NR-1:0] exp_rr;
    forever begin
      @(negedge clk);
      s_rr     = req_ready & req_valid;
      s_hs_in  = cnv_valid_in & cnv_ready_in;
      s_op     = cnv_fixed_point;
      s_hs_out = cnv_valid_out & cnv_ready_out;
      if (!rst) begin
        chk("reset_outputs", {busy, out_valid, cnv_valid_in, cnv_ready_out, timeout_err,
                              req_ready, out_id, out_data, cnv_fixed_point}, '0);
        sb.delete();
        m_ptr = 0; m_phase = 0; wcnt = 0; exp_err = 1'b0;
        continue;
      end
      chk("timeout_err", 64'(timeout_err), 64'(exp_err));
      case (m_phase)
        0: begin
          g = -1;
          for (int k = 0; k < NR; k++)
            if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
          exp_rr = '0;
          if (g >= 0) exp_rr[g] = 1'b1;
          chk("idle_grant", {busy, out_valid, cnv_valid_in, cnv_ready_out, req_ready},
              {4'b0000, exp_rr});
          if (g >= 0 && req_ready[g]) begin
            e.id = 2'(g);
            e.op = req_data[g*W +: W];
            e.data = fix2float(e.op);
            sb.push_back(e);
            glog.push_back(g);
            hs_cnt[g]++;
            n_grant++;
            m_phase = 1;
          end
        end
        1: begin
          e = sb[0];
          chk("issue", {busy, out_valid, cnv_valid_in, cnv_ready_out, req_ready,
                        cnv_fixed_point}, {4'b1010, {NR{1'b0}}, e.op});
          if (cnv_valid_in && cnv_ready_in) begin
            m_phase = 2;
            wcnt = 0;
          end
        end
        2: begin
          wcnt++;
          chk("wait", {busy, out_valid, cnv_valid_in, cnv_ready_out, req_ready},
              {4'b1001, {NR{1'b0}}});
          if (cnv_valid_out && cnv_ready_out) begin
            m_phase = 3;
          end else if (wcnt == TO) begin
            e = sb.pop_front();
            m_ptr = (int'(e.id) + 1) % NR;
            exp_err = 1'b1;
            n_tmo++;
            m_phase = 0;
          end
        end
        default: begin
          e = sb[0];
          chk("deliver", {busy, out_valid, cnv_valid_in, cnv_ready_out, req_ready,
                          out_id, out_data}, {4'b1100, {NR{1'b0}}, e.id, e.data});
          if (out_valid && out_ready) begin
            void'(sb.pop_front());
            m_ptr = (int'(e.id) + 1) % NR;
            dlog.push_back(out_data);
            ilog.push_back(int'(out_id));
            n_deliv++;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // Requester and converter models, stepped just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        cv_phase = 0;
        cnv_valid_out = 1'b0;
        cnv_data_out = '0;
        continue;
      end
      for (int i = 0; i < NR; i++) begin
        if (s_rr[i]) begin
          req_valid[i] = sticky[i];
        end else if (auto_req) begin
          if (!req_valid[i] && int'($urandom_range(0, 99)) < 30) begin
            req_data[i*W +: W] = 16'($urandom);
            req_valid[i] = 1'b1;
          end else if (req_valid[i] && int'($urandom_range(0, 99)) < 3) begin
            req_valid[i] = 1'b0;
          end
        end
      end
      if (auto_req) out_ready = (int'($urandom_range(0, 99)) < 60);
      case (cv_phase)
        0: if (s_hs_in) begin
          cv_res = fix2float(s_op);
          if (cv_hang || int'($urandom_range(0, 99)) < cv_hang_pct) begin
            cv_phase = 0;
          end else begin
            cv_left = (cv_lat < 0) ? int'($urandom_range(0, 4)) : cv_lat;
            if (cv_left == 0) begin
              cnv_valid_out = 1'b1;
              cnv_data_out = cv_res;
              cv_phase = 2;
            end else begin
              cv_phase = 1;
            end
          end
        end
        1: begin
          cv_left--;
          if (cv_left == 0) begin
            cnv_valid_out = 1'b1;
            cnv_data_out = cv_res;
            cv_phase = 2;
          end
        end
        default: if (s_hs_out) begin
          cnv_valid_out = 1'b0;
          cnv_data_out = '0;
          cv_phase = 0;
        end
      endcase
      cnv_ready_in = (cv_ready_pct >= 100) ? 1'b1
                                           : (int'($urandom_range(0, 99)) < cv_ready_pct);
    end
  end

  function automatic int ev_val(input int which);
    case (which)
      0: return n_deliv;
      1: return n_tmo;
      2: return n_grant;
      3: return int'(m_phase == 0 && req_valid == '0);
      4: return int'(m_phase == 3);
      default: return int'(m_phase == 2);
    endcase
  endfunction

  task automatic wait_ev(input int which, input int target, input string name);
    int n = 0;
    while (ev_val(which) < target && n < 600) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, 64'(ev_val(which) >= target), 64'd1);
  endtask

  task automatic raise(input int i, input logic [W-1:0] d);
    req_data[i*W +: W] = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic edge_drive();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    edge_drive();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  logic [15:0] t2_op  [4] = '{16'h0100, 16'h0280, 16'h03C0, 16'h0520};
  logic [31:0] t2_exp [4] = '{32'h3F800000, 32'h40200000, 32'h40700000, 32'h40A40000};
  int          t3_exp [4] = '{1, 3, 0, 1};

  initial begin
    int base, gb, hb[NR], d0;
    req_valid = '0; req_data = '0; out_ready = 1'b0;
    cnv_ready_in = 1'b0; cnv_valid_out = 1'b0; cnv_data_out = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Single request, 2-cycle converter
    edge_drive();
    out_ready = 1'b1;
    raise(0, 16'h0100);
    wait_ev(0, 1, "t1_done");
    chk("t1_data", 64'(dlog[$]), 64'h3F800000);
    chk("t1_id", 64'(ilog[$]), 64'd0);
    @(negedge clk);
    #1 chk("t1_busy_low", 64'(busy), 64'd0);

    // Four simultaneous requests from a freshly reset pointer
    do_reset();
    base = dlog.size();
    for (int i = 0; i < NR; i++) hb[i] = hs_cnt[i];
    edge_drive();
    for (int i = 0; i < NR; i++) raise(i, t2_op[i]);
    wait_ev(0, n_deliv + 4, "t2_done");
    wait_ev(3, 1, "t2_idle");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_id%0d", i), 64'(ilog[base+i]), 64'(i));
      chk($sformatf("t2_data%0d", i), 64'(dlog[base+i]), 64'(t2_exp[i]));
      chk($sformatf("t2_ready_once%0d", i), 64'(hs_cnt[i] - hb[i]), 64'd1);
    end

    // Fairness: requester 1 stays valid, 0 and 3 join after its first grant
    gb = glog.size();
    edge_drive();
    sticky[1] = 1'b1;
    raise(1, 16'h0180);
    wait_ev(2, n_grant + 1, "t3_first");
    edge_drive();
    raise(0, 16'h0200);
    raise(3, 16'h0300);
    wait_ev(2, gb + 4, "t3_grants");
    sticky[1] = 1'b0;
    wait_ev(3, 1, "t3_idle");
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_order%0d", i), 64'(glog[gb+i]), 64'(t3_exp[i]));

    // Backpressure in result delivery
    edge_drive();
    out_ready = 1'b0;
    raise(2, 16'h1234);
    wait_ev(4, 1, "t4_deliver");
    edge_drive();
    raise(0, 16'h0440);
    repeat (10) begin
      @(negedge clk);
      #1;
      chk("t4_no_grant", 64'(req_ready), 64'd0);
      chk("t4_held", {out_valid, out_id, out_data}, {1'b1, 2'd2, 32'h4191A000});
    end
    gb = n_grant;
    edge_drive();
    out_ready = 1'b1;
    wait_ev(2, gb + 1, "t4_next");
    chk("t4_next_id", 64'(glog[$]), 64'd0);
    wait_ev(3, 1, "t4_idle");

    // Result on the last allowed wait cycle, then a converter that never answers
    edge_drive();
    cv_lat = TO - 1;
    d0 = n_deliv;
    raise(3, 16'h0040);
    wait_ev(0, d0 + 1, "t5_late_done");
    chk("t5_late_data", 64'(dlog[$]), 64'h3E800000);
    chk("t5_late_noerr", 64'(timeout_err), 64'd0);
    edge_drive();
    cv_hang = 1'b1;
    d0 = n_deliv;
    raise(1, 16'h0100);
    wait_ev(1, n_tmo + 1, "t5_timeout");
    @(negedge clk);
    #1;
    chk("t5_err_set", {timeout_err, busy}, 2'b10);
    chk("t5_no_result", 64'(n_deliv), 64'(d0));
    edge_drive();
    cv_hang = 1'b0;
    cv_lat = 1;
    raise(2, 16'h0200);
    wait_ev(0, d0 + 1, "t5_after");
    chk("t5_after_data", {ilog[$], dlog[$]}, {32'd2, 32'h40000000});
    chk("t5_err_sticky", 64'(timeout_err), 64'd1);

    // Asynchronous reset in the middle of a wait
    edge_drive();
    cv_hang = 1'b1;
    raise(0, 16'h0300);
    wait_ev(5, 1, "t6_in_wait");
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;
    #1 chk("t6_async", {busy, out_valid, cnv_valid_in, cnv_ready_out, timeout_err, req_ready,
                        out_id, out_data, cnv_fixed_point}, '0);
    @(posedge clk);
    #2 rst = 1'b1;
    cv_hang = 1'b0;
    cv_lat = 2;
    edge_drive();
    d0 = n_deliv;
    raise(0, 16'h8000);
    wait_ev(0, d0 + 1, "t6_after");
    chk("t6_after_data", {ilog[$], dlog[$]}, {32'd0, 32'h43000000});

    // Randomized traffic with a stalling converter and random backpressure
    d0 = n_deliv;
    edge_drive();
    cv_lat = -1;
    cv_ready_pct = 70;
    cv_hang_pct = 4;
    auto_req = 1'b1;
    repeat (2000) @(posedge clk);
    #2 auto_req = 1'b0;
    out_ready = 1'b1;
    wait_ev(3, 1, "rand_drain");
    chk("rand_progress", 64'(n_deliv - d0 > 50), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
